// File: rtl/bank2rs_pkg.sv
// Shared Bank->Vertex_RS beat format and sizing constants, also used by Vertex_RS.
package bank2rs_pkg;

  localparam int NUM_FV_LINE = 4;
  localparam int FV_SIZE     = 16;
  localparam int MAX_FV_NUM  = 64;
  localparam int MAX_NODE_ID = 16;
  localparam int BANK_ADDR_W = 8;
  localparam int NODE_ID_W   = $clog2(MAX_NODE_ID);

  typedef struct packed {
    logic                                sos;
    logic                                eos;
    logic [NODE_ID_W-1:0]                node_id;
    logic [NUM_FV_LINE-1:0][FV_SIZE-1:0] fv_data;
  } bank2rs_t;

  function automatic int lines_for(input int num_fv, input int line_fv);
    return (num_fv + line_fv - 1) / line_fv;
  endfunction

endpackage

// File: rtl/bank2rs_beat_stage.sv
// Read-return alignment, FV slot masking and sos/eos tagging for the beat stream.
module bank2rs_beat_stage
  import bank2rs_pkg::*;
#(
  parameter int LINE_FV = NUM_FV_LINE,
  parameter int NUM_W   = $clog2(MAX_FV_NUM) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_vld,
  input  logic                       issue_sos,
  input  logic                       issue_eos,
  input  logic [NUM_W-1:0]           issue_beat,
  input  logic [NUM_W-1:0]           num_fv,
  input  logic [NODE_ID_W-1:0]       node_id,
  input  logic [LINE_FV*FV_SIZE-1:0] bank_rd_data,
  output bank2rs_t                   beat_out,
  output logic                       stream_done
);

  logic                             ret_vld;
  logic                             ret_sos;
  logic                             ret_eos;
  logic [NUM_W-1:0]                 ret_beat;
  logic [NUM_W-1:0]                 ret_num;
  logic [NODE_ID_W-1:0]             ret_node;
  logic [LINE_FV-1:0][FV_SIZE-1:0]  fv_masked;

  // Beat tags ride one cycle behind the issue so they line up with bank data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_vld  <= 1'b0;
      ret_sos  <= 1'b0;
      ret_eos  <= 1'b0;
      ret_beat <= '0;
      ret_num  <= '0;
      ret_node <= '0;
    end else begin
      ret_vld  <= issue_vld;
      ret_sos  <= issue_sos;
      ret_eos  <= issue_eos;
      ret_beat <= issue_beat;
      ret_num  <= num_fv;
      ret_node <= node_id;
    end
  end

  // Slots past the node's FV count are zeroed; this also blanks whole pad beats.
  for (genvar j = 0; j < LINE_FV; j++) begin : g_slot
    assign fv_masked[j] = (ret_vld && ((int'(ret_beat) * LINE_FV + j) < int'(ret_num)))
                          ? bank_rd_data[j*FV_SIZE +: FV_SIZE] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_out <= '0;
    end else begin
      beat_out.sos     <= ret_vld && ret_sos;
      beat_out.eos     <= ret_vld && ret_eos;
      beat_out.node_id <= ret_vld ? ret_node : '0;
      beat_out.fv_data <= fv_masked;
    end
  end

  assign stream_done = beat_out.eos;

endmodule

// File: rtl/bank2rs_streamer.sv
// Streams one node's FV lines from the bank to Vertex_RS as a fixed-length sos..eos burst.
module bank2rs_streamer
  import bank2rs_pkg::*;
#(
  parameter int LINE_FV = NUM_FV_LINE,
  parameter int MAX_FV  = MAX_FV_NUM,
  parameter int ADDR_W  = BANK_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [NODE_ID_W-1:0]       req_node_id,
  input  logic [ADDR_W-1:0]          req_base_addr,
  input  logic [$clog2(MAX_FV):0]    req_num_fv,
  output logic                       bank_rd_en,
  output logic [ADDR_W-1:0]          bank_rd_addr,
  input  logic [LINE_FV*FV_SIZE-1:0] bank_rd_data,
  input  logic                       RS_available,
  output bank2rs_t                   Bank2RS_out,
  output logic                       stream_done
);

  localparam int NUM_W = $clog2(MAX_FV) + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_RS = 2'd1;
  localparam logic [1:0] S_ISSUE   = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]           state;
  logic [NODE_ID_W-1:0] node_q;
  logic [ADDR_W-1:0]    base_q;
  logic [NUM_W-1:0]     num_q;
  logic [NUM_W-1:0]     lines_q;
  logic [NUM_W-1:0]     beats_q;
  logic [NUM_W-1:0]     beat_q;
  logic [NUM_W-1:0]     req_lines;
  logic [NUM_W-1:0]     req_beats;
  logic                 issue;
  logic                 last_beat;

  // Streams are never shorter than two beats so sos and eos never share a beat.
  assign req_lines = NUM_W'(lines_for(int'(req_num_fv), LINE_FV));
  assign req_beats = (req_lines < NUM_W'(2)) ? NUM_W'(2) : req_lines;

  assign req_ready    = (state == S_IDLE);
  assign issue        = (state == S_ISSUE);
  assign last_beat    = (beat_q == beats_q - NUM_W'(1));
  assign bank_rd_en   = issue && (beat_q < lines_q);
  assign bank_rd_addr = bank_rd_en ? base_q + ADDR_W'(beat_q) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      node_q  <= '0;
      base_q  <= '0;
      num_q   <= '0;
      lines_q <= '0;
      beats_q <= '0;
      beat_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            node_q  <= req_node_id;
            base_q  <= req_base_addr;
            num_q   <= req_num_fv;
            lines_q <= req_lines;
            beats_q <= req_beats;
            beat_q  <= '0;
            state   <= S_WAIT_RS;
          end
        end
        S_WAIT_RS: begin
          if (RS_available) state <= S_ISSUE;
        end
        // RS_available is deliberately ignored from here on: no mid-stream stall.
        S_ISSUE: begin
          beat_q <= beat_q + NUM_W'(1);
          if (last_beat) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (stream_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  bank2rs_beat_stage #(
    .LINE_FV (LINE_FV),
    .NUM_W   (NUM_W)
  ) u_beat_stage (
    .clk          (clk),
    .reset        (reset),
    .issue_vld    (issue),
    .issue_sos    (issue && (beat_q == '0)),
    .issue_eos    (issue && last_beat),
    .issue_beat   (beat_q),
    .num_fv       (num_q),
    .node_id      (node_q),
    .bank_rd_data (bank_rd_data),
    .beat_out     (Bank2RS_out),
    .stream_done  (stream_done)
  );

endmodule

// File: tb/tb_bank2rs_streamer.sv
// Scoreboard bench: bank model, Vertex_RS capture model and per-scenario tasks.
module tb_bank2rs_streamer;
  import bank2rs_pkg::*;

  localparam int LF = NUM_FV_LINE;
  localparam int AW = BANK_ADDR_W;
  localparam int NW = $clog2(MAX_FV_NUM) + 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic [NODE_ID_W-1:0]  req_node_id = '0;
  logic [AW-1:0]         req_base_addr = '0;
  logic [NW-1:0]         req_num_fv = '0;
  logic                  bank_rd_en;
  logic [AW-1:0]         bank_rd_addr;
  logic [LF*FV_SIZE-1:0] bank_rd_data = '0;
  logic                  RS_available = 1'b0;
  bank2rs_t              Bank2RS_out;
  logic                  stream_done;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int hs_cyc = 0;
  bit in_stream = 1'b0;
  bit mon_on = 1'b0;

  bank2rs_t             exp_q[$];
  bank2rs_t             mon_e;
  logic [NODE_ID_W-1:0] acc_ids[$];
  logic [NODE_ID_W-1:0] cap_ids[$];
  logic [AW-1:0]        rd_log[$];
  int                   sos_cycs[$];
  int                   eos_cycs[$];

  bank2rs_streamer dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_node_id   (req_node_id),
    .req_base_addr (req_base_addr),
    .req_num_fv    (req_num_fv),
    .bank_rd_en    (bank_rd_en),
    .bank_rd_addr  (bank_rd_addr),
    .bank_rd_data  (bank_rd_data),
    .RS_available  (RS_available),
    .Bank2RS_out   (Bank2RS_out),
    .stream_done   (stream_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [FV_SIZE-1:0] fv_val(input logic [AW-1:0] a, input int j);
    return FV_SIZE'(32'hA000 + 32'(a) * 16 + j);
  endfunction

  // Bank: registered read, junk on idle cycles so masking of pad beats is visible.
  always @(posedge clk) begin
    for (int j = 0; j < LF; j++)
      bank_rd_data[j*FV_SIZE +: FV_SIZE] <= bank_rd_en ? fv_val(bank_rd_addr, j) : FV_SIZE'(16'hDEAD);
  end

  // Vertex_RS model: captures sos..eos bursts and checks them against the scoreboard.
  always @(negedge clk) begin
    if (reset && mon_on) begin
      if (bank_rd_en) rd_log.push_back(bank_rd_addr);
      else begin
        n_chk++;
        if (bank_rd_addr !== '0) begin
          n_fail++; $display("FAIL rd_addr_idle: got %h want 0", bank_rd_addr);
        end
      end
      if (in_stream || Bank2RS_out.sos) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL beat_unexpected: got %h, none expected", Bank2RS_out);
        end else begin
          mon_e = exp_q.pop_front();
          if (Bank2RS_out !== mon_e) begin
            n_fail++; $display("FAIL beat: got %h want %h", Bank2RS_out, mon_e);
          end
        end
        n_chk++;
        if (stream_done !== Bank2RS_out.eos) begin
          n_fail++; $display("FAIL stream_done: got %b want %b", stream_done, Bank2RS_out.eos);
        end
        if (Bank2RS_out.sos) sos_cycs.push_back(cyc);
        if (Bank2RS_out.eos) begin
          eos_cycs.push_back(cyc); cap_ids.push_back(Bank2RS_out.node_id); in_stream = 1'b0;
        end else in_stream = 1'b1;
      end else begin
        n_chk++;
        if (Bank2RS_out !== '0 || stream_done !== 1'b0) begin
          n_fail++; $display("FAIL idle_out: got %h done %b want 0", Bank2RS_out, stream_done);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [NODE_ID_W-1:0] id, input logic [AW-1:0] base, input int num);
    int w, lines, nb;
    bank2rs_t e;
    req_valid = 1'b1; req_node_id = id; req_base_addr = base; req_num_fv = NW'(num);
    w = 0;
    while (req_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    n_chk++;
    if (w >= 200) begin
      n_fail++; $display("FAIL req_ready_timeout: got 0 after %0d cycles want 1", w);
      req_valid = 1'b0;
      return;
    end
    hs_cyc = cyc;
    lines = (num + LF - 1) / LF;
    nb = (lines < 2) ? 2 : lines;
    for (int k = 0; k < nb; k++) begin
      e = '0; e.sos = (k == 0); e.eos = (k == nb - 1); e.node_id = id;
      for (int j = 0; j < LF; j++)
        if (k * LF + j < num) e.fv_data[j] = fv_val(AW'(int'(base) + k), j);
      exp_q.push_back(e);
    end
    acc_ids.push_back(id);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    while ((exp_q.size() != 0 || req_ready !== 1'b1) && w < 300) begin @(negedge clk); w++; end
    n_chk++;
    if (w >= 300) begin
      n_fail++; $display("FAIL %s_timeout: %0d beats outstanding want 0", tag, exp_q.size());
    end
  endtask

  task automatic clear_logs();
    rd_log.delete(); sos_cycs.delete(); eos_cycs.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; mon_on = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (Bank2RS_out !== '0) begin n_fail++; $display("FAIL rst_out: got %h want 0", Bank2RS_out); end
    n_chk++;
    if (bank_rd_en !== 1'b0 || bank_rd_addr !== '0) begin
      n_fail++; $display("FAIL rst_rd: got en %b addr %h want 0 0", bank_rd_en, bank_rd_addr);
    end
    n_chk++;
    if (stream_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", stream_done); end
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    mon_on = 1'b1;
  endtask

  task automatic test_full_stream();
    clear_logs(); RS_available = 1'b1;
    send(4'd1, 8'h10, 16);
    wait_done("full");
    n_chk++;
    if (rd_log.size() != 4) begin n_fail++; $display("FAIL full_nreads: got %0d want 4", rd_log.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (rd_log[k] !== AW'(16 + k)) begin
        n_fail++; $display("FAIL full_addr%0d: got %h want %h", k, rd_log[k], AW'(16 + k));
      end
    end
    n_chk++;
    if (sos_cycs.size() != 1 || sos_cycs[0] - acc_cyc != 3) begin
      n_fail++; $display("FAIL full_latency: got %0d sos, delta %0d want 1, 3", sos_cycs.size(),
                         (sos_cycs.size() > 0) ? sos_cycs[0] - acc_cyc : -1);
    end
  endtask

  task automatic test_pad();
    clear_logs(); RS_available = 1'b1;
    send(4'd2, 8'h40, 3);
    wait_done("pad");
    n_chk++;
    if (rd_log.size() != 1 || rd_log[0] !== 8'h40) begin
      n_fail++; $display("FAIL pad_reads: got %0d reads want 1 at 40", rd_log.size());
    end
  endtask

  task automatic test_rs_wait();
    int t;
    clear_logs(); RS_available = 1'b0;
    send(4'd3, 8'h20, 8);
    repeat (10) @(negedge clk);
    n_chk++;
    if (rd_log.size() != 0 || sos_cycs.size() != 0) begin
      n_fail++; $display("FAIL rs_hold: got %0d reads %0d sos want 0 0", rd_log.size(), sos_cycs.size());
    end
    RS_available = 1'b1; t = cyc;
    @(negedge clk);
    RS_available = 1'b0;
    wait_done("rs_wait");
    n_chk++;
    if (sos_cycs.size() != 1 || sos_cycs[0] != t + 3) begin
      n_fail++; $display("FAIL rs_latency: got sos at %0d want %0d", (sos_cycs.size() > 0) ? sos_cycs[0] : -1, t + 3);
    end
    n_chk++;
    if (rd_log.size() != 2 || rd_log[0] !== 8'h20 || rd_log[1] !== 8'h21) begin
      n_fail++; $display("FAIL rs_reads: got %0d reads want 2 (20,21)", rd_log.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_logs(); RS_available = 1'b1;
    send(4'd5, 8'h30, 8);
    send(4'd6, 8'h50, 8);
    wait_done("b2b");
    n_chk++;
    if (eos_cycs.size() != 2 || sos_cycs.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d sos %0d eos want 2 2", sos_cycs.size(), eos_cycs.size());
    end else begin
      n_chk++;
      if (hs_cyc != eos_cycs[0] + 1) begin
        n_fail++; $display("FAIL b2b_accept: got cycle %0d want %0d", hs_cyc, eos_cycs[0] + 1);
      end
      n_chk++;
      if (sos_cycs[1] - eos_cycs[0] < 2) begin
        n_fail++; $display("FAIL b2b_gap: got %0d want >=2", sos_cycs[1] - eos_cycs[0]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] want [4];
    clear_logs(); RS_available = 1'b1;
    send(4'd7, AW'((1 << AW) - 2), 16);
    wait_done("wrap");
    want[0] = AW'((1 << AW) - 2); want[1] = AW'((1 << AW) - 1); want[2] = '0; want[3] = AW'(1);
    n_chk++;
    if (rd_log.size() != 4) begin n_fail++; $display("FAIL wrap_nreads: got %0d want 4", rd_log.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (rd_log[k] !== want[k]) begin
        n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", k, rd_log[k], want[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    int n_eos;
    clear_logs(); RS_available = 1'b1;
    send(4'd8, 8'h60, 16);
    while (Bank2RS_out.sos !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    n_chk++;
    if (w >= 50) begin n_fail++; $display("FAIL mid_sos_timeout: got no sos want sos"); end
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (Bank2RS_out !== '0 || stream_done !== 1'b0 || bank_rd_en !== 1'b0 || bank_rd_addr !== '0) begin
      n_fail++; $display("FAIL mid_rst_out: got %h done %b en %b want all 0", Bank2RS_out, stream_done, bank_rd_en);
    end
    exp_q.delete(); in_stream = 1'b0; void'(acc_ids.pop_back());
    n_eos = eos_cycs.size();
    @(negedge clk);
    reset = 1'b1; rd_log.delete();
    #1;
    n_chk++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", req_ready); end
    repeat (12) @(negedge clk);
    n_chk++;
    if (eos_cycs.size() != n_eos || rd_log.size() != 0) begin
      n_fail++; $display("FAIL mid_resume: got %0d eos %0d reads want 0 0", eos_cycs.size() - n_eos, rd_log.size());
    end
  endtask

  task automatic test_order();
    n_chk++;
    if (cap_ids.size() != acc_ids.size()) begin
      n_fail++; $display("FAIL order_count: got %0d streams want %0d", cap_ids.size(), acc_ids.size());
    end else for (int i = 0; i < cap_ids.size(); i++) begin
      n_chk++;
      if (cap_ids[i] !== acc_ids[i]) begin
        n_fail++; $display("FAIL order%0d: got node %0d want %0d", i, cap_ids[i], acc_ids[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_pad();
    test_rs_wait();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_order();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
